// File: rtl/hk_pkg.sv
// Shared housekeeping SPI arbiter definitions: FSM encoding, default widths and timeouts.
package hk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_RESP  = 3'd4
  } hk_state_e;

  localparam int unsigned HK_NREQ      = 3;
  localparam int unsigned HK_DW        = 16;
  localparam int unsigned HK_START_TMO = 16;
  localparam int unsigned HK_BSY_TMO   = 65535;
  localparam int unsigned HK_GAP       = 8;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hk_rr_arbiter.sv
// Combinational round-robin picker: search starts one past the pointer and wraps modulo NREQ.
module hk_rr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            any_o,
  output logic [PW-1:0]   ptr_o
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    ptr_o = ptr_i;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = PW'((32'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_o      = idx;
      end
    end
  end

endmodule

// File: rtl/hk_spi_arbiter.sv
// Shares the housekeeping SPI master between NREQ requesters, sequencing load/start/busy
// per transaction with start and busy watchdogs and an enforced inter-transaction gap.
module hk_spi_arbiter
  import hk_pkg::*;
#(
  parameter int unsigned NREQ      = HK_NREQ,
  parameter int unsigned DW        = HK_DW,
  parameter int unsigned START_TMO = HK_START_TMO,
  parameter int unsigned BSY_TMO   = HK_BSY_TMO,
  parameter int unsigned GAP       = HK_GAP
) (
  input  logic              clk_i,
  input  logic              pll_ff_rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*DW-1:0] req_wr_h_i,
  input  logic [NREQ*DW-1:0] req_wr_l_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic              err_o,
  output logic [DW-1:0]     rd_dat_o,
  output logic              spi_start_o,
  output logic [DW-1:0]     spi_wr_h_o,
  output logic [DW-1:0]     spi_wr_l_o,
  input  logic [DW-1:0]     spi_rd_l_i,
  input  logic              spi_bsy_i,
  output logic [7:0]        sts_o
);

  localparam int unsigned   PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);
  localparam logic [15:0]   GAP_LD  = 16'(GAP);

  hk_state_e       state_q, state_d;
  logic            settle_q, settle_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [15:0]     gap_q, gap_d;
  logic [15:0]     wdog_q, wdog_d, wdog_inc;
  logic [3:0]      tmo_q, tmo_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            start_q, start_d;
  logic [DW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   wrh_q, wrh_d;
  logic [DW-1:0]   wrl_q, wrl_d;

  logic [NREQ-1:0] arb_gnt;
  logic            arb_any;
  logic [PW-1:0]   arb_ptr;
  logic            start_tmo;
  logic            bsy_tmo;

  hk_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .any_o (arb_any),
    .ptr_o (arb_ptr)
  );

  // Timeout fires on the cycle whose count would reach the limit, so the error
  // completion lands exactly TMO cycles after the watched phase began.
  assign wdog_inc  = sat_inc16(wdog_q);
  assign start_tmo = (32'(wdog_inc) >= START_TMO);
  assign bsy_tmo   = (32'(wdog_inc) >= BSY_TMO);

  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      state_q  <= ST_IDLE;
      settle_q <= 1'b0;
      ptr_q    <= PTR_RST;
      gap_q    <= '0;
      wdog_q   <= '0;
      tmo_q    <= '0;
      gnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      rd_q     <= '0;
      wrh_q    <= '0;
      wrl_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ptr_q    <= ptr_d;
      gap_q    <= gap_d;
      wdog_q   <= wdog_d;
      tmo_q    <= tmo_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      start_q  <= start_d;
      rd_q     <= rd_d;
      wrh_q    <= wrh_d;
      wrl_q    <= wrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (gap_q == '0 && arb_any) state_d = ST_LOAD;
      ST_LOAD:  if (settle_q) state_d = ST_START;
      ST_START: if (spi_bsy_i || start_tmo) state_d = spi_bsy_i ? ST_BUSY : ST_RESP;
      ST_BUSY:  if (!spi_bsy_i || bsy_tmo) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    settle_d = settle_q;
    ptr_d    = ptr_q;
    gap_d    = gap_q;
    wdog_d   = wdog_q;
    tmo_d    = tmo_q;
    gnt_d    = gnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    start_d  = 1'b0;
    rd_d     = rd_q;
    wrh_d    = wrh_q;
    wrl_d    = wrl_q;
    unique case (state_q)
      ST_IDLE: begin
        settle_d = 1'b0;
        wdog_d   = '0;
        if (gap_q != '0) begin
          gap_d = gap_q - 16'd1;
        end else if (arb_any) begin
          gnt_d = arb_gnt;
          ptr_d = arb_ptr;
          for (int unsigned k = 0; k < NREQ; k++) begin
            if (arb_gnt[k]) begin
              wrh_d = req_wr_h_i[k*DW +: DW];
              wrl_d = req_wr_l_i[k*DW +: DW];
            end
          end
        end
      end
      ST_LOAD: begin
        settle_d = 1'b1;
        start_d  = settle_q;
      end
      ST_START: begin
        wdog_d = wdog_inc;
        if (spi_bsy_i) begin
          // The cycle that saw busy high already counts toward the busy budget.
          wdog_d = 16'd1;
        end else if (start_tmo) begin
          done_d = 1'b1;
          err_d  = 1'b1;
          tmo_d  = (tmo_q == 4'hF) ? tmo_q : tmo_q + 4'd1;
        end
      end
      ST_BUSY: begin
        wdog_d = wdog_inc;
        if (!spi_bsy_i) begin
          done_d = 1'b1;
          rd_d   = spi_rd_l_i;
        end else if (bsy_tmo) begin
          done_d = 1'b1;
          err_d  = 1'b1;
          tmo_d  = (tmo_q == 4'hF) ? tmo_q : tmo_q + 4'd1;
        end
      end
      ST_RESP: begin
        gnt_d = '0;
        gap_d = GAP_LD;
      end
      default: ;
    endcase
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q ? gnt_q : '0;
  assign err_o       = err_q;
  assign rd_dat_o    = rd_q;
  assign spi_start_o = start_q;
  assign spi_wr_h_o  = wrh_q;
  assign spi_wr_l_o  = wrl_q;
  assign sts_o       = {tmo_q, state_q, (state_q != ST_IDLE)};

endmodule

// File: tb/tb_hk_spi_arbiter.sv
// Directed bench for hk_spi_arbiter: behavioural SPI master model plus a completion scoreboard.
module tb_hk_spi_arbiter;

  logic        clk;
  logic        pll_ff_rst;
  logic [2:0]  req;
  logic [47:0] req_wr_h;
  logic [47:0] req_wr_l;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        err;
  logic [15:0] rd;
  logic        spi_start;
  logic [15:0] spi_wr_h;
  logic [15:0] spi_wr_l;
  logic [15:0] spi_rd;
  logic        spi_bsy;
  logic [7:0]  sts;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int mode = 0;        // 0: normal, 1: busy never rises, 2: busy stuck high
  int model_len = 40;

  typedef struct {
    logic [2:0]  gnt;
    logic        err;
    logic [15:0] rd;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  hk_spi_arbiter #(
    .NREQ      (3),
    .DW        (16),
    .START_TMO (16),
    .BSY_TMO   (100),
    .GAP       (8)
  ) dut (
    .clk_i       (clk),
    .pll_ff_rst  (pll_ff_rst),
    .req_i       (req),
    .req_wr_h_i  (req_wr_h),
    .req_wr_l_i  (req_wr_l),
    .gnt_o       (gnt),
    .done_o      (done),
    .err_o       (err),
    .rd_dat_o    (rd),
    .spi_start_o (spi_start),
    .spi_wr_h_o  (spi_wr_h),
    .spi_wr_l_o  (spi_wr_l),
    .spi_rd_l_i  (spi_rd),
    .spi_bsy_i   (spi_bsy),
    .sts_o       (sts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [2:0] g, input logic er, input logic [15:0] r);
    exp_t x;
    x.gnt = g;
    x.err = er;
    x.rd  = r;
    sb.push_back(x);
  endfunction

  task automatic wait_start(input string tag, input int limit);
    int n = 0;
    while (spi_start !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(spi_start), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int limit, output int n);
    n = 0;
    while (done === 3'b000 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done != 3'b000), 32'd1);
  endtask

  // SPI master model: answers a start pulse with busy; read data is wr_l ^ 0x00FF.
  initial begin
    spi_bsy = 1'b0;
    spi_rd  = '0;
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1 && mode != 1) begin
        spi_bsy = 1'b1;
        if (mode == 2) begin
          while (mode == 2) @(negedge clk);
        end else begin
          repeat (model_len) @(negedge clk);
          spi_rd = spi_wr_l ^ 16'h00FF;
        end
        spi_bsy = 1'b0;
      end
    end
  end

  // Completion monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (spi_start === 1'b1) n_start++;
    if (done !== 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_gnt", 32'(done), 32'(e.gnt));
        chk("done_err", 32'(err), 32'(e.err));
        chk("done_rd", 32'(rd), 32'(e.rd));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int idle;
    logic [2:0] exp_g;
    logic [15:0] last_rd;

    pll_ff_rst = 1'b0;
    req        = '0;
    req_wr_h   = '0;
    req_wr_l   = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_start", 32'(spi_start), 32'd0);
    chk("rst_wr_h", 32'(spi_wr_h), 32'd0);
    chk("rst_wr_l", 32'(spi_wr_l), 32'd0);
    chk("rst_sts", 32'(sts), 32'd0);
    pll_ff_rst = 1'b1;

    // Single CPU transaction
    mode = 0;
    model_len = 40;
    req_wr_h[15:0] = 16'h8012;
    req_wr_l[15:0] = 16'h00AA;
    push(3'b001, 1'b0, 16'h0055);
    req = 3'b001;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'b001);
    chk("t1_wr_h", 32'(spi_wr_h), 32'h8012);
    chk("t1_wr_l", 32'(spi_wr_l), 32'h00AA);
    @(negedge clk);
    chk("t1_start_early", 32'(spi_start), 32'd0);
    @(negedge clk);
    chk("t1_start", 32'(spi_start), 32'd1);
    chk("t1_sts_busy", 32'(sts[0]), 32'd1);
    wait_done("t1_done", 100, n);
    req = '0;
    @(negedge clk);
    chk("t1_rd_hold", 32'(rd), 32'h0055);
    chk("t1_start_count", 32'(n_start), 32'd1);

    // Round robin with all requesters held
    pll_ff_rst = 1'b0;
    @(negedge clk);
    pll_ff_rst = 1'b1;
    req_wr_h = {16'hC302, 16'hB201, 16'hA100};
    req_wr_l = {16'h3302, 16'h2201, 16'h1100};
    for (int i = 0; i < 4; i++) begin
      exp_g = 3'b001 << (i % 3);
      push(exp_g, 1'b0, req_wr_l[(i % 3)*16 +: 16] ^ 16'h00FF);
    end
    model_len = 5;
    req = 3'b111;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_g = 3'b001 << (i % 3);
      chk("rr_gnt", 32'(gnt), 32'(exp_g));
      chk("rr_wr_h", 32'(spi_wr_h), 32'(req_wr_h[(i % 3)*16 +: 16]));
      wait_done("rr_done", 100, n);
      if (i < 3) begin
        idle = 0;
        @(negedge clk);
        while (gnt === 3'b000 && idle < 200) begin
          idle++;
          @(negedge clk);
        end
        chk("rr_gap", 32'(idle >= 9), 32'd1);
      end else begin
        req = '0;
      end
    end
    last_rd = 16'h1100 ^ 16'h00FF;

    // Busy never rises: start watchdog
    mode = 1;
    push(3'b001, 1'b1, last_rd);
    req = 3'b001;
    wait_start("t3_start", 60);
    wait_done("t3_done", 100, n);
    chk("t3_latency", 32'(n), 32'd16);
    req = '0;
    @(negedge clk);
    chk("t3_tmo_cnt", 32'(sts[7:4]), 32'd1);
    chk("t3_rd_keep", 32'(rd), 32'(last_rd));

    // Busy stuck high: busy watchdog, then a normal transaction
    mode = 2;
    push(3'b100, 1'b1, last_rd);
    req = 3'b100;
    wait_start("t4_start", 60);
    wait_done("t4_done", 300, n);
    chk("t4_latency", 32'(n), 32'd100);
    mode = 0;
    req = '0;
    @(negedge clk);
    chk("t4_tmo_cnt", 32'(sts[7:4]), 32'd2);
    model_len = 10;
    req_wr_l[31:16] = 16'h5A5A;
    push(3'b010, 1'b0, 16'h5AA5);
    req = 3'b010;
    wait_done("t4_recover", 200, n);
    req = '0;

    // Requester drops its request mid-transaction
    model_len = 20;
    req_wr_l[31:16] = 16'h0F0F;
    push(3'b010, 1'b0, 16'h0FF0);
    req = 3'b010;
    wait_start("t5_start", 60);
    repeat (5) @(negedge clk);
    chk("t5_state_busy", 32'(sts[3:1]), 32'd3);
    req = '0;
    wait_done("t5_done", 200, n);

    // Reset during BUSY
    model_len = 40;
    req = 3'b001;
    wait_start("t6_start", 60);
    repeat (5) @(negedge clk);
    #2;
    pll_ff_rst = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(gnt), 32'd0);
    chk("t6_rst_start", 32'(spi_start), 32'd0);
    chk("t6_rst_sts", 32'(sts), 32'd0);
    chk("t6_rst_rd", 32'(rd), 32'd0);
    req = '0;
    repeat (3) @(negedge clk);
    pll_ff_rst = 1'b1;
    n = 0;
    while (spi_bsy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_model_idle", 32'(spi_bsy), 32'd0);
    chk("t6_sts_idle", 32'(sts), 32'd0);
    push(3'b100, 1'b0, 16'h3302 ^ 16'h00FF);
    req = 3'b100;
    @(negedge clk);
    chk("t6_gnt", 32'(gnt), 32'b100);
    wait_done("t6_done", 200, n);
    req = '0;

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("start_total", 32'(n_start), 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
